io_sequencer: RTL and testbench

IO_SEQUENCER -- requirements
Module: io_sequencer

---
 rtl/io_seq_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/io_sequencer.sv | 110 +++++++++++
 tb/tb_io_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and defaults for the IN/OUT instruction sequencer.
package io_seq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    DONE       = 2'd3
  } seq_state_t;

  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int SW_W            = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; two cycles of latency.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/io_sequencer.sv
// Stalls the CPU on an IN instruction until the button is released, then held for
// HOLD_CYCLES; captures the synchronized switches. OUT latches dado1 when not stalled.
module io_sequencer
  import io_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_request,
  input  logic              OutOP,
  input  logic              confirm,
  input  logic [SW_W-1:0]   switches,
  input  logic [DATA_W-1:0] dado1,
  output logic              stall,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic              busy
);

  localparam int                CNT_W     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_valid;
  logic [DATA_W-1:0] r_in_data;
  logic [DATA_W-1:0] r_out_value;
  logic              r_out_valid;
  logic [SW_W-1:0]   w_sw_sync;
  logic              w_stall;

  sync_2ff #(.W(SW_W)) u_sw_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (switches),
    .o_q     (w_sw_sync)
  );

  // Combinational so the PC holds in the very cycle the IN instruction shows up.
  assign w_stall = input_request && (r_state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
    end else begin
      r_in_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (input_request) r_state <= ARM;
        end
        ARM: begin
          // A press left over from before the instruction must be released first.
          if (!input_request) begin
            r_state <= IDLE;
          end else if (!confirm) begin
            r_state <= WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!input_request) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!confirm) begin
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state    <= DONE;
            r_cnt      <= '0;
            r_in_valid <= 1'b1;
            r_in_data  <= DATA_W'(w_sw_sync);
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_value <= '0;
      r_out_valid <= 1'b0;
    end else if (OutOP && !w_stall) begin
      r_out_value <= dado1;
      r_out_valid <= 1'b1;
    end
  end

  assign stall     = w_stall;
  assign in_valid  = r_in_valid;
  assign in_data   = r_in_data;
  assign out_value = r_out_value;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer: capture, pre-press, bounce, abort, reset and OUT paths.
module tb_io_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        input_request;
  logic        OutOP;
  logic        confirm;
  logic [9:0]  switches;
  logic [31:0] dado1;
  logic        stall;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] out_value;
  logic        out_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  io_sequencer #(.HOLD_CYCLES(4), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_request (input_request),
    .OutOP         (OutOP),
    .confirm       (confirm),
    .switches      (switches),
    .dado1         (dado1),
    .stall         (stall),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_value     (out_value),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; input_request = 1'b0; OutOP = 1'b0; confirm = 1'b0;
    switches = 10'h000; dado1 = 32'h0;
    #2;
    check("rst_in_valid", {31'b0, in_valid}, 32'd0);
    check("rst_in_data", in_data, 32'h0);
    check("rst_out_value", out_value, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall_lo", {31'b0, stall}, 32'd0);
    input_request = 1'b1;
    #1;
    check("rst_stall_hi", {31'b0, stall}, 32'd1);
    input_request = 1'b0;
    step(); step();
    reset = 1'b1;

    // Basic capture
    switches = 10'h2A5;
    step(); step(); step();
    input_request = 1'b1;
    #1;
    check("cap_stall_same_cycle", {31'b0, stall}, 32'd1);
    check("cap_idle_busy", {31'b0, busy}, 32'd0);
    step();
    check("cap_arm_busy", {31'b0, busy}, 32'd1);
    step();
    confirm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("cap_no_valid_early", {31'b0, in_valid}, 32'd0);
      check("cap_stall_hold", {31'b0, stall}, 32'd1);
      step();
    end
    check("cap_in_valid", {31'b0, in_valid}, 32'd1);
    check("cap_stall_done", {31'b0, stall}, 32'd0);
    check("cap_in_data", in_data, 32'h0000_02A5);
    input_request = 1'b0; confirm = 1'b0;
    step();
    check("cap_valid_one_cycle", {31'b0, in_valid}, 32'd0);
    check("cap_back_idle", {31'b0, busy}, 32'd0);
    check("cap_data_hold", in_data, 32'h0000_02A5);

    // Button already pressed when IN arrives
    switches = 10'h155; confirm = 1'b1; input_request = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("pre_stuck_arm", {31'b0, in_valid}, 32'd0);
    end
    check("pre_data_kept", in_data, 32'h0000_02A5);
    confirm = 1'b0;
    step();
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pre_no_valid_early", {31'b0, in_valid}, 32'd0);
    end
    step();
    check("pre_in_valid", {31'b0, in_valid}, 32'd1);
    check("pre_in_data", in_data, 32'h0000_0155);
    input_request = 1'b0; confirm = 1'b0;
    step();

    // Bounce: 3 high, 1 low, 4 high
    switches = 10'h0F0; input_request = 1'b1;
    step(); step();
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bnc_first_burst", {31'b0, in_valid}, 32'd0);
    end
    confirm = 1'b0;
    step();
    check("bnc_gap", {31'b0, in_valid}, 32'd0);
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bnc_second_burst", {31'b0, in_valid}, 32'd0);
    end
    step();
    check("bnc_in_valid", {31'b0, in_valid}, 32'd1);
    check("bnc_in_data", in_data, 32'h0000_00F0);

    // Back-to-back IN with the button still held
    step();
    check("b2b_idle", {31'b0, busy}, 32'd0);
    check("b2b_stall", {31'b0, stall}, 32'd1);
    step();
    check("b2b_arm", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("b2b_needs_release", {31'b0, in_valid}, 32'd0);
    end
    input_request = 1'b0;
    step();
    check("b2b_abort_arm", {31'b0, busy}, 32'd0);

    // Abort in WAIT_PRESS
    switches = 10'h3FF; confirm = 1'b0; input_request = 1'b1;
    step(); step();
    confirm = 1'b1;
    step(); step();
    input_request = 1'b0;
    step();
    check("abt_idle", {31'b0, busy}, 32'd0);
    check("abt_no_valid", {31'b0, in_valid}, 32'd0);
    step(); step();
    check("abt_no_valid_late", {31'b0, in_valid}, 32'd0);
    check("abt_data_kept", in_data, 32'h0000_00F0);
    confirm = 1'b0;

    // OUT
    OutOP = 1'b1; dado1 = 32'hDEAD_BEEF;
    #1;
    check("out_valid_before", {31'b0, out_valid}, 32'd0);
    step();
    check("out_value", out_value, 32'hDEAD_BEEF);
    check("out_valid", {31'b0, out_valid}, 32'd1);
    dado1 = 32'h1234_5678; input_request = 1'b1;
    step();
    check("out_suppressed", out_value, 32'hDEAD_BEEF);
    check("out_valid_sticky", {31'b0, out_valid}, 32'd1);
    OutOP = 1'b0; input_request = 1'b0;
    step();

    // Async reset mid WAIT_PRESS
    input_request = 1'b1; confirm = 1'b0;
    step(); step();
    confirm = 1'b1;
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    check("mrst_in_data", in_data, 32'h0);
    check("mrst_out_value", out_value, 32'h0);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_in_valid", {31'b0, in_valid}, 32'd0);
    check("mrst_stall", {31'b0, stall}, 32'd1);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mrst_no_pulse", {31'b0, in_valid}, 32'd0);
    end
    input_request = 1'b0; confirm = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
